error_link_tx: RTL and testbench

//   Serial transmitter carrying one node's signed phase-detector error to a neighbouring node over a single wire.
//   It samples the node's error on each rising edge of the node's divided generated clock (gen_div8).

---
 rtl/error_link_tx.sv | 172 +++++++++++++++++
 tb/tb_error_link_tx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/error_link_tx.sv
// Serial transmitter for one node's signed phase-detector error: framed, even-parity, LSB first.
// Samples are taken on synchronised rising edges of sample_i; one pending slot absorbs samples arriving mid-frame.
module error_link_tx #(
  parameter int unsigned ERROR_WIDTH = 5,
  parameter int unsigned BIT_CYCLES  = 4,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned OVR_WIDTH   = 8
) (
  input  logic                   fpga_clk_i,
  input  logic                   reset_n_i,
  input  logic                   enable_i,
  input  logic                   sample_i,
  input  logic [ERROR_WIDTH-1:0] error_i,
  output logic                   link_o,
  output logic                   busy_o,
  output logic                   drop_o,
  output logic [OVR_WIDTH-1:0]   overrun_o
);

  localparam int unsigned CNT_W   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned IDX_MAX = (ERROR_WIDTH > STOP_BITS) ? ERROR_WIDTH : STOP_BITS;
  localparam int unsigned IDX_W   = $clog2(IDX_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                 r_state;
  logic                   r_s1;
  logic                   r_s2;
  logic                   r_s3;
  logic [CNT_W-1:0]       r_cnt;
  logic [IDX_W-1:0]       r_idx;
  logic [ERROR_WIDTH-1:0] r_shift;
  logic                   r_parity;
  logic                   r_pend_valid;
  logic [ERROR_WIDTH-1:0] r_pend_data;
  logic                   r_link;
  logic                   r_busy;
  logic                   r_drop;
  logic [OVR_WIDTH-1:0]   r_ovr;

  logic                   w_rise;
  logic                   w_take;
  logic                   w_bit_end;
  logic                   w_frame_end;
  logic                   w_pend_ok;
  logic [ERROR_WIDTH-1:0] w_next_word;

  assign w_rise      = r_s2 & ~r_s3;
  assign w_take      = w_rise & enable_i;
  assign w_bit_end   = (r_cnt == CNT_W'(BIT_CYCLES - 1));
  assign w_frame_end = (r_state == S_STOP) && w_bit_end && (r_idx == IDX_W'(STOP_BITS - 1));
  // A disabled link discards whatever is pending rather than sending it.
  assign w_pend_ok   = r_pend_valid & enable_i;
  assign w_next_word = w_pend_ok ? r_pend_data : error_i;

  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state      <= S_IDLE;
      r_s1         <= 1'b0;
      r_s2         <= 1'b0;
      r_s3         <= 1'b0;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_shift      <= '0;
      r_parity     <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_data  <= '0;
      r_link       <= 1'b1;
      r_busy       <= 1'b0;
      r_drop       <= 1'b0;
      r_ovr        <= '0;
    end else begin
      r_s1   <= sample_i;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_drop <= 1'b0;

      if (!enable_i) begin
        r_pend_valid <= 1'b0;
      end

      if (r_state != S_IDLE) begin
        r_cnt <= w_bit_end ? '0 : r_cnt + CNT_W'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_shift  <= error_i;
            r_parity <= ^error_i;
            r_link   <= 1'b0;
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_state  <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_link  <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_idx   <= '0;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            if (r_idx == IDX_W'(ERROR_WIDTH - 1)) begin
              r_link  <= r_parity;
              r_state <= S_PARITY;
            end else begin
              r_link  <= r_shift[0];
              r_shift <= r_shift >> 1;
              r_idx   <= r_idx + IDX_W'(1);
            end
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_link  <= 1'b1;
            r_idx   <= '0;
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_frame_end) begin
            // Back-to-back frame: pending word first, else a sample arriving on this very edge.
            if (w_pend_ok || w_take) begin
              r_shift      <= w_next_word;
              r_parity     <= ^w_next_word;
              r_link       <= 1'b0;
              r_state      <= S_START;
              r_pend_valid <= w_pend_ok & w_take;
              if (w_pend_ok && w_take) begin
                r_pend_data <= error_i;
              end
            end else begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else if (w_bit_end) begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Mid-frame samples go to the single pending slot; overwriting a full slot is an overrun.
      if ((r_state != S_IDLE) && !w_frame_end && w_take) begin
        r_pend_data  <= error_i;
        r_pend_valid <= 1'b1;
        if (r_pend_valid) begin
          r_drop <= 1'b1;
          if (r_ovr != {OVR_WIDTH{1'b1}}) begin
            r_ovr <= r_ovr + OVR_WIDTH'(1);
          end
        end
      end
    end
  end

  assign link_o    = r_link;
  assign busy_o    = r_busy;
  assign drop_o    = r_drop;
  assign overrun_o = r_ovr;

endmodule

// File: tb/tb_error_link_tx.sv
// Directed bench for error_link_tx: a table of single frames plus hand-written
// back-to-back, overrun, reset-abort, disable and saturation sequences.
`timescale 1ns/1ps
module tb_error_link_tx;

  logic       clk = 1'b0;
  logic       reset_n_i;
  logic       enable_i;
  logic       sample_i;
  logic [4:0] error_i;
  logic       link_o;
  logic       busy_o;
  logic       drop_o;
  logic [7:0] overrun_o;

  always #5 clk = ~clk;

  error_link_tx #(
    .ERROR_WIDTH(5),
    .BIT_CYCLES (4),
    .STOP_BITS  (1),
    .OVR_WIDTH  (8)
  ) dut (
    .fpga_clk_i(clk),
    .reset_n_i (reset_n_i),
    .enable_i  (enable_i),
    .sample_i  (sample_i),
    .error_i   (error_i),
    .link_o    (link_o),
    .busy_o    (busy_o),
    .drop_o    (drop_o),
    .overrun_o (overrun_o)
  );

  typedef struct {
    logic [4:0] err;
    logic [7:0] frame;
  } vec_t;

  vec_t vecs[6];
  int   n_pass  = 0;
  int   n_total = 0;
  int   drops   = 0;

  always @(negedge clk) if (drop_o === 1'b1) drops++;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // Called at a negedge: present a sample and drop sample_i two cycles later.
  task automatic kick(input logic [4:0] e);
    error_i  = e;
    sample_i = 1'b1;
    fork
      begin
        repeat (2) @(negedge clk);
        sample_i = 1'b0;
      end
    join_none
  endtask

  task automatic wait_start(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (link_o !== 1'b0 && n < 40);
  endtask

  // Entered at the negedge just after the START edge; leaves at the last cycle of the frame.
  task automatic rx_frame(input logic [7:0] exp, input string nm);
    logic [7:0] got;
    int         bcnt;
    got  = '0;
    bcnt = 0;
    for (int c = 0; c < 32; c++) begin
      if (c > 0) @(negedge clk);
      if (busy_o === 1'b1) bcnt++;
      if (c % 4 == 1) got[c/4] = link_o;
    end
    chk({nm, " frame"}, 32'(got), 32'(exp));
    chk({nm, " busy cycles"}, 32'(bcnt), 32'd32);
  endtask

  task automatic idle_check(input int n, input string nm);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (link_o !== 1'b1 || busy_o !== 1'b0) bad++;
    end
    chk(nm, 32'(bad), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int d0;
    int guard;

    vecs[0] = '{5'b10110, 8'hEC};
    vecs[1] = '{5'b00000, 8'h80};
    vecs[2] = '{5'b10000, 8'hE0};
    vecs[3] = '{5'b01111, 8'h9E};
    vecs[4] = '{5'b01010, 8'h94};
    vecs[5] = '{5'b11111, 8'hFE};

    reset_n_i = 1'b0;
    enable_i  = 1'b1;
    sample_i  = 1'b0;
    error_i   = '0;
    repeat (3) @(negedge clk);
    chk("reset link", 32'(link_o), 32'd1);
    chk("reset busy", 32'(busy_o), 32'd0);
    chk("reset drop", 32'(drop_o), 32'd0);
    chk("reset overrun", 32'(overrun_o), 32'd0);
    reset_n_i = 1'b1;
    idle_check(100, "idle after reset");

    // Single frames from the table.
    for (int i = 0; i < 6; i++) begin
      kick(vecs[i].err);
      wait_start(lat);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'd3);
      rx_frame(vecs[i].frame, $sformatf("vec%0d", i));
      @(negedge clk);
      chk($sformatf("vec%0d end busy", i), 32'(busy_o), 32'd0);
      chk($sformatf("vec%0d end link", i), 32'(link_o), 32'd1);
      repeat (6) @(negedge clk);
    end

    // Two samples ten cycles apart: back-to-back frames, no drop.
    d0 = drops;
    kick(5'd3);
    wait_start(lat);
    chk("b2b latency", 32'(lat), 32'd3);
    fork
      rx_frame(8'h86, "b2b first");
      begin
        repeat (7) @(negedge clk);
        kick(5'b11111);
      end
    join
    @(negedge clk);
    chk("b2b no gap link", 32'(link_o), 32'd0);
    chk("b2b no gap busy", 32'(busy_o), 32'd1);
    rx_frame(8'hFE, "b2b second");
    @(negedge clk);
    chk("b2b end busy", 32'(busy_o), 32'd0);
    chk("b2b drops", 32'(drops - d0), 32'd0);
    repeat (6) @(negedge clk);

    // Three samples within one frame: middle one is overwritten.
    d0 = drops;
    kick(5'd1);
    wait_start(lat);
    fork
      rx_frame(8'hC2, "ovr first");
      begin
        repeat (5) @(negedge clk);
        kick(5'd2);
        repeat (8) @(negedge clk);
        kick(5'd7);
      end
    join
    @(negedge clk);
    chk("ovr no gap link", 32'(link_o), 32'd0);
    rx_frame(8'hCE, "ovr second");
    @(negedge clk);
    chk("ovr end busy", 32'(busy_o), 32'd0);
    chk("ovr drops", 32'(drops - d0), 32'd1);
    chk("ovr overrun", 32'(overrun_o), 32'd1);
    repeat (6) @(negedge clk);

    // Reset in the middle of a frame releases the line without a clock edge.
    kick(5'd9);
    wait_start(lat);
    repeat (12) @(negedge clk);
    reset_n_i = 1'b0;
    #1;
    chk("abort link", 32'(link_o), 32'd1);
    chk("abort busy", 32'(busy_o), 32'd0);
    chk("abort overrun", 32'(overrun_o), 32'd0);
    repeat (2) @(negedge clk);
    reset_n_i = 1'b1;
    idle_check(60, "after abort idle");
    chk("after abort overrun", 32'(overrun_o), 32'd0);

    // Disable mid-frame: frame completes, later samples ignored.
    kick(5'b01111);
    wait_start(lat);
    chk("dis latency", 32'(lat), 32'd3);
    fork
      rx_frame(8'h9E, "dis");
      begin
        repeat (6) @(negedge clk);
        enable_i = 1'b0;
        repeat (6) @(negedge clk);
        kick(5'd2);
        repeat (8) @(negedge clk);
        kick(5'd7);
      end
    join
    @(negedge clk);
    chk("dis end busy", 32'(busy_o), 32'd0);
    idle_check(60, "disabled idle");
    enable_i = 1'b1;
    kick(5'd2);
    wait_start(lat);
    chk("reen latency", 32'(lat), 32'd3);
    rx_frame(8'hC4, "reen");
    @(negedge clk);
    chk("reen end busy", 32'(busy_o), 32'd0);
    idle_check(40, "reen single frame");

    // Continuous samples every 4 cycles drive the overrun counter into saturation.
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      sample_i = ((i % 4) < 2);
      error_i  = 5'(i);
    end
    sample_i = 1'b0;
    guard = 0;
    while (busy_o !== 1'b0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("sat drained", 32'(busy_o), 32'd0);
    chk("sat overrun", 32'(overrun_o), 32'hFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
